// File: rtl/irq_entry_seq.sv
// ---------------------------------------------------------------------------
// irq_entry_seq
//
// Interrupt entry/return sequencer that sits between the C0 interrupt
// register file and the pipeline.
//
// On interrupt entry it takes a pending, enabled IRQ and flushes the
// pipeline. It waits for the drain to finish, saves EPC and issues the RC0
// IRQ op. It then redirects fetch to the handler vector and raises the
// nesting depth.
//
// On return, an ERET issues the RC0 RET op, redirects fetch to EPC and
// lowers the depth.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   en                  run enable; low freezes the FSM and mutes all pulses
//   ivld, inum          unmasked pending IRQ and its number (from C0)
//   ie_glb              global interrupt enable
//   eret                ERET decoded in ID, held until stall_o releases
//   resume_pc           PC of the oldest uncommitted instruction
//   epc_r               current C0 EPC value
//   rc0_op              NONE / IRQ / RET op pulse to C0
//   epc_we, epc_w       EPC write strobe and data
//   flush               pipeline flush pulse
//   stall_o             fetch/decode stall, high whenever the FSM is busy
//   redir, redir_pc     fetch redirect pulse and target
//   depth               current nesting depth
//   eret_err            pulse: ERET arrived with nothing to return from
//   irq_cnt             taken-IRQ counter
//
// Optional feature macro: IRQ_SEQ_STATS_EN
//   Defined:   irq_cnt counts the IRQs taken and saturates at 16'hFFFF.
//   Undefined: irq_cnt is tied to zero.
// ---------------------------------------------------------------------------

`ifndef RC0_OP_NBIT
`define RC0_OP_NBIT 2
`endif
`ifndef RC0_OP_NONE
`define RC0_OP_NONE 2'd0
`endif
`ifndef RC0_OP_IRQ
`define RC0_OP_IRQ 2'd1
`endif
`ifndef RC0_OP_RET
`define RC0_OP_RET 2'd2
`endif

module irq_entry_seq #(
    parameter int          NIRQ      = 3,
    parameter int          NBIT_IRQ  = 2,
    parameter logic [31:0] VEC_BASE  = 32'h0000_1000,
    parameter int          VEC_SHIFT = 4,
    parameter int          DRAIN_CYC = 2,
    parameter int          MAX_NEST  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    ivld,
    input  logic [NBIT_IRQ-1:0]     inum,
    input  logic                    ie_glb,
    input  logic                    eret,
    input  logic [31:0]             resume_pc,
    input  logic [31:0]             epc_r,
    output logic [`RC0_OP_NBIT-1:0] rc0_op,
    output logic                    epc_we,
    output logic [31:0]             epc_w,
    output logic                    flush,
    output logic                    stall_o,
    output logic                    redir,
    output logic [31:0]             redir_pc,
    output logic [1:0]              depth,
    output logic                    eret_err,
    output logic [15:0]             irq_cnt
);

    typedef enum logic [2:0] {IDLE, DRAIN, SAVE, VECTOR, RET} state_t;

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYC - 1);

    state_t                    state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [NBIT_IRQ-1:0]       num_q, num_d;
    logic [1:0]                depth_d;
    logic                      flush_d, epc_we_d, redir_d, eret_err_d;
    logic [`RC0_OP_NBIT-1:0]   rc0_op_d;
    logic [31:0]               epc_w_d, redir_pc_d;
    logic                      irq_take;
    logic [31:0]               vec_pc;

    // An IRQ number outside the implemented lines is never taken, so a
    // corrupted inum cannot vector past the end of the handler table.
    assign irq_take = ivld && ie_glb
                   && (32'(depth) < 32'(MAX_NEST))
                   && (32'(inum) < 32'(NIRQ));

    assign vec_pc = VEC_BASE + (32'(num_q) << VEC_SHIFT);

    // Each output is registered against the state being entered.
    // A pulse is therefore visible in the same cycle that the FSM
    // occupies that state.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        num_d      = num_q;
        depth_d    = depth;
        flush_d    = 1'b0;
        epc_we_d   = 1'b0;
        epc_w_d    = epc_w;
        rc0_op_d   = `RC0_OP_NONE;
        redir_d    = 1'b0;
        redir_pc_d = redir_pc;
        eret_err_d = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    // ERET wins over a simultaneous IRQ.
                    if (eret) begin
                        if (depth != 2'd0) begin
                            state_d    = RET;
                            rc0_op_d   = `RC0_OP_RET;
                            redir_d    = 1'b1;
                            redir_pc_d = epc_r;
                            depth_d    = depth - 2'd1;
                        end else begin
                            eret_err_d = 1'b1;
                        end
                    end else if (irq_take) begin
                        state_d = DRAIN;
                        flush_d = 1'b1;
                        cnt_d   = CNT_INIT;
                        num_d   = inum;
                    end
                end
                DRAIN: begin
                    if (cnt != '0) begin
                        cnt_d = cnt - CNT_W'(1);
                    end else begin
                        state_d  = SAVE;
                        epc_we_d = 1'b1;
                        epc_w_d  = resume_pc;
                        rc0_op_d = `RC0_OP_IRQ;
                    end
                end
                SAVE: begin
                    state_d    = VECTOR;
                    redir_d    = 1'b1;
                    redir_pc_d = vec_pc;
                    depth_d    = depth + 2'd1;
                end
                VECTOR:  state_d = IDLE;
                RET:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            num_q    <= '0;
            depth    <= 2'd0;
            flush    <= 1'b0;
            epc_we   <= 1'b0;
            epc_w    <= 32'h0;
            rc0_op   <= `RC0_OP_NONE;
            redir    <= 1'b0;
            redir_pc <= 32'h0;
            eret_err <= 1'b0;
            stall_o  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            num_q    <= num_d;
            depth    <= depth_d;
            flush    <= flush_d;
            epc_we   <= epc_we_d;
            epc_w    <= epc_w_d;
            rc0_op   <= rc0_op_d;
            redir    <= redir_d;
            redir_pc <= redir_pc_d;
            eret_err <= eret_err_d;
            stall_o  <= (state_d != IDLE);
        end
    end

`ifdef IRQ_SEQ_STATS_EN
    // Counts on the SAVE->VECTOR step, together with the depth increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_cnt <= 16'h0000;
        end else if (en && (state == SAVE) && (irq_cnt != 16'hFFFF)) begin
            irq_cnt <= irq_cnt + 16'h0001;
        end
    end
`else
    assign irq_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_irq_entry_seq.sv
// ---------------------------------------------------------------------------
// tb_irq_entry_seq
//
// Directed self-checking bench for irq_entry_seq. It drives inputs 1 ns
// after each rising clock edge and samples the registered outputs at the
// same point.
// ---------------------------------------------------------------------------

module tb_irq_entry_seq;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_IRQ  = 2'd1;
    localparam logic [1:0] OP_RET  = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ivld;
    logic [1:0]  inum;
    logic        ie_glb;
    logic        eret;
    logic [31:0] resume_pc;
    logic [31:0] epc_r;
    logic [1:0]  rc0_op;
    logic        epc_we;
    logic [31:0] epc_w;
    logic        flush;
    logic        stall_o;
    logic        redir;
    logic [31:0] redir_pc;
    logic [1:0]  depth;
    logic        eret_err;
    logic [15:0] irq_cnt;

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    irq_entry_seq dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ivld      (ivld),
        .inum      (inum),
        .ie_glb    (ie_glb),
        .eret      (eret),
        .resume_pc (resume_pc),
        .epc_r     (epc_r),
        .rc0_op    (rc0_op),
        .epc_we    (epc_we),
        .epc_w     (epc_w),
        .flush     (flush),
        .stall_o   (stall_o),
        .redir     (redir),
        .redir_pc  (redir_pc),
        .depth     (depth),
        .eret_err  (eret_err),
        .irq_cnt   (irq_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] n,
                                 input logic ie, input logic e);
        ivld   = v;
        inum   = n;
        ie_glb = ie;
        eret   = e;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expIrqCnt();
`ifdef IRQ_SEQ_STATS_EN
        return 32'(exp_cnt);
`else
        return 32'h0;
`endif
    endfunction

    // Full entry from IDLE back to IDLE, checking the redirect cycle.
    task automatic takeIrq(input logic [1:0] n, input logic [31:0] exp_pc,
                           input logic [1:0] exp_depth);
        applyStimulus(1'b1, n, 1'b1, 1'b0);
        tick();
        checkOutput("entry_flush", 32'(flush), 32'd1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        repeat (3) tick();
        exp_cnt++;
        checkOutput("entry_redir", 32'(redir), 32'd1);
        checkOutput("entry_redir_pc", redir_pc, exp_pc);
        checkOutput("entry_depth", 32'(depth), 32'(exp_depth));
        checkOutput("entry_irq_cnt", 32'(irq_cnt), expIrqCnt());
        tick();
    endtask

    task automatic doEret(input logic [31:0] pc, input logic [1:0] exp_depth);
        epc_r = pc;
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        tick();
        checkOutput("eret_rc0_op", 32'(rc0_op), 32'(OP_RET));
        checkOutput("eret_redir_pc", redir_pc, pc);
        checkOutput("eret_depth", 32'(depth), 32'(exp_depth));
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        resume_pc = 32'h0;
        epc_r     = 32'h0;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset values.
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_depth", 32'(depth), 32'd0);
        checkOutput("rst_rc0_op", 32'(rc0_op), 32'(OP_NONE));
        checkOutput("rst_epc_w", epc_w, 32'h0);
        checkOutput("rst_redir_pc", redir_pc, 32'h0);
        checkOutput("rst_irq_cnt", 32'(irq_cnt), 32'h0);
        rst = 1'b0;

        // 1: reset while draining.
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        tick();
        checkOutput("t1_flush", 32'(flush), 32'd1);
        checkOutput("t1_stall", 32'(stall_o), 32'd1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("t1_drain_stall", 32'(stall_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t1_rst_stall", 32'(stall_o), 32'd0);
        checkOutput("t1_rst_flush", 32'(flush), 32'd0);
        checkOutput("t1_rst_depth", 32'(depth), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("t1_no_epc_we", 32'(epc_we), 32'd0);
        end

        // 2: basic entry, inum=2.
        resume_pc = 32'h0000_0040;
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        tick();
        checkOutput("t2_flush", 32'(flush), 32'd1);
        checkOutput("t2_epc_we_early", 32'(epc_we), 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("t2_flush_done", 32'(flush), 32'd0);
        checkOutput("t2_epc_we_t2", 32'(epc_we), 32'd0);
        tick();
        checkOutput("t2_epc_we", 32'(epc_we), 32'd1);
        checkOutput("t2_epc_w", epc_w, 32'h0000_0040);
        checkOutput("t2_rc0_irq", 32'(rc0_op), 32'(OP_IRQ));
        checkOutput("t2_redir_early", 32'(redir), 32'd0);
        tick();
        exp_cnt++;
        checkOutput("t2_redir", 32'(redir), 32'd1);
        checkOutput("t2_redir_pc", redir_pc, 32'h0000_1020);
        checkOutput("t2_depth", 32'(depth), 32'd1);
        checkOutput("t2_epc_we_done", 32'(epc_we), 32'd0);
        checkOutput("t2_irq_cnt", 32'(irq_cnt), expIrqCnt());
        tick();
        checkOutput("t2_idle", 32'(stall_o), 32'd0);
        checkOutput("t2_redir_done", 32'(redir), 32'd0);

        // 3: return from depth 1.
        epc_r = 32'h0000_0040;
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        tick();
        checkOutput("t3_rc0_ret", 32'(rc0_op), 32'(OP_RET));
        checkOutput("t3_redir", 32'(redir), 32'd1);
        checkOutput("t3_redir_pc", redir_pc, 32'h0000_0040);
        checkOutput("t3_depth", 32'(depth), 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("t3_idle", 32'(stall_o), 32'd0);

        // 4: ERET and IRQ together at depth 1.
        takeIrq(2'd0, 32'h0000_1000, 2'd1);
        epc_r = 32'h0000_0080;
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b1);
        tick();
        checkOutput("t4_rc0_ret", 32'(rc0_op), 32'(OP_RET));
        checkOutput("t4_redir_pc", redir_pc, 32'h0000_0080);
        checkOutput("t4_no_flush", 32'(flush), 32'd0);
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        tick();
        checkOutput("t4_flush_gap", 32'(flush), 32'd0);
        tick();
        checkOutput("t4_flush", 32'(flush), 32'd1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        repeat (3) tick();
        exp_cnt++;
        checkOutput("t4_redir_pc_irq", redir_pc, 32'h0000_1010);
        checkOutput("t4_depth", 32'(depth), 32'd1);
        checkOutput("t4_irq_cnt", 32'(irq_cnt), expIrqCnt());
        tick();

        // 5: nesting limit, then unwind and underflow.
        takeIrq(2'd2, 32'h0000_1020, 2'd2);
        takeIrq(2'd0, 32'h0000_1000, 2'd3);
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t5_no_flush", 32'(flush), 32'd0);
        end
        checkOutput("t5_idle_at_max", 32'(stall_o), 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        doEret(32'h0000_0300, 2'd2);
        doEret(32'h0000_0304, 2'd1);
        doEret(32'h0000_0308, 2'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        tick();
        checkOutput("t5_eret_err", 32'(eret_err), 32'd1);
        checkOutput("t5_err_no_redir", 32'(redir), 32'd0);
        checkOutput("t5_err_depth", 32'(depth), 32'd0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        tick();
        checkOutput("t5_eret_err_once", 32'(eret_err), 32'd0);
        checkOutput("t5_depth_after", 32'(depth), 32'd0);

        // 6: freeze at the point of entering SAVE; ie_glb drops mid-sequence.
        resume_pc = 32'h0000_0200;
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        tick();
        checkOutput("t6_flush", 32'(flush), 32'd1);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t6_frozen_epc_we", 32'(epc_we), 32'd0);
            checkOutput("t6_frozen_stall", 32'(stall_o), 32'd1);
        end
        en = 1'b1;
        tick();
        checkOutput("t6_epc_we", 32'(epc_we), 32'd1);
        checkOutput("t6_epc_w", epc_w, 32'h0000_0200);
        checkOutput("t6_rc0_irq", 32'(rc0_op), 32'(OP_IRQ));
        tick();
        exp_cnt++;
        checkOutput("t6_redir", 32'(redir), 32'd1);
        checkOutput("t6_redir_pc", redir_pc, 32'h0000_1010);
        checkOutput("t6_depth", 32'(depth), 32'd1);
        checkOutput("t6_irq_cnt", 32'(irq_cnt), expIrqCnt());
        tick();
        checkOutput("t6_idle", 32'(stall_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
